// File: rtl/mul_cell_arbiter.sv
// Round-robin sharing of one pipelined low-product multiplier cell between two requesters.
// Granted operands are registered onto the cell; a tag pipeline routes each result back.
module mul_cell_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_src1,
    input  logic [WIDTH-1:0] req0_src2,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_src1,
    input  logic [WIDTH-1:0] req1_src2,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,

    output logic [WIDTH-1:0] mul_src1,
    output logic [WIDTH-1:0] mul_src2,
    input  logic [WIDTH-1:0] mul_result,

    output logic             busy
);

    localparam int unsigned DEPTH = LATENCY + 1;

    logic             r_ptr;
    logic [DEPTH-1:0] r_tag_vld;
    logic [DEPTH-1:0] r_tag_port;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_port;

    // Grant only issues to a valid requester, so a grant is already an acceptance.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset_n && en) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = ~r_ptr;
                w_gnt1 = r_ptr;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_port     = w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= 1'b0;
            r_src1 <= '0;
            r_src2 <= '0;
        end else if (w_accept) begin
            r_ptr  <= ~w_port;
            r_src1 <= w_port ? req1_src1 : req0_src1;
            r_src2 <= w_port ? req1_src2 : req0_src2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld  <= {r_tag_vld[DEPTH-2:0], w_accept};
            r_tag_port <= {r_tag_port[DEPTH-2:0], w_port};
        end
    end

    assign mul_src1 = r_src1;
    assign mul_src2 = r_src2;

    // The last tag stage lines up with the cell output.
    assign rsp0_valid  = r_tag_vld[LATENCY] & ~r_tag_port[LATENCY];
    assign rsp1_valid  = r_tag_vld[LATENCY] & r_tag_port[LATENCY];
    assign rsp0_result = rsp0_valid ? mul_result : '0;
    assign rsp1_result = rsp1_valid ? mul_result : '0;

    // An op in its response cycle has completed and no longer counts as in flight.
    assign busy = w_accept | (|r_tag_vld[LATENCY-1:0]);

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Bench for mul_cell_arbiter: two instances (LATENCY 1 and 3) on shared stimulus,
// each with a behavioural multiplier cell, checked against a queue-based reference model.
module tb_mul_cell_arbiter;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         en;
    logic         v0;
    logic         v1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;

    logic [1:0]        rdy0;
    logic [1:0]        rdy1;
    logic [1:0]        rv0;
    logic [1:0]        rv1;
    logic [1:0]        bsy;
    logic [1:0][W-1:0] rr0;
    logic [1:0][W-1:0] rr1;
    logic [1:0][W-1:0] ms1;
    logic [1:0][W-1:0] ms2;
    logic [1:0][W-1:0] mr;

    mul_cell_arbiter #(.WIDTH(W), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .en(en),
        .req0_valid(v0), .req0_ready(rdy0[0]), .req0_src1(a0), .req0_src2(b0),
        .rsp0_valid(rv0[0]), .rsp0_result(rr0[0]),
        .req1_valid(v1), .req1_ready(rdy1[0]), .req1_src1(a1), .req1_src2(b1),
        .rsp1_valid(rv1[0]), .rsp1_result(rr1[0]),
        .mul_src1(ms1[0]), .mul_src2(ms2[0]), .mul_result(mr[0]), .busy(bsy[0])
    );

    mul_cell_arbiter #(.WIDTH(W), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .en(en),
        .req0_valid(v0), .req0_ready(rdy0[1]), .req0_src1(a0), .req0_src2(b0),
        .rsp0_valid(rv0[1]), .rsp0_result(rr0[1]),
        .req1_valid(v1), .req1_ready(rdy1[1]), .req1_src1(a1), .req1_src2(b1),
        .rsp1_valid(rv1[1]), .rsp1_result(rr1[1]),
        .mul_src1(ms1[1]), .mul_src2(ms2[1]), .mul_result(mr[1]), .busy(bsy[1])
    );

    // Behavioural multiplier cells: unregistered inputs, LATENCY output registers.
    logic [W-1:0] cell_a;
    logic [W-1:0] cell_b0;
    logic [W-1:0] cell_b1;
    logic [W-1:0] cell_b2;
    always @(posedge clk) begin
        cell_a  <= ms1[0] * ms2[0];
        cell_b0 <= ms1[1] * ms2[1];
        cell_b1 <= cell_b0;
        cell_b2 <= cell_b1;
    end
    assign mr[0] = cell_a;
    assign mr[1] = cell_b2;

    // Reference model: outstanding ops with the cycle their response is due.
    typedef struct {
        int unsigned  due;
        logic         port;
        logic [W-1:0] prod;
        int           dut;
    } op_t;

    op_t          q[$];
    int unsigned  cyc;
    logic         m_pri;
    logic [W-1:0] m_s1;
    logic [W-1:0] m_s2;
    int           n_pass;
    int           n_total;

    typedef struct {
        logic         port;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] prod;
    } vec_t;
    vec_t tab[7];

    function automatic void chk(string nm, int d, logic [W-1:0] act, logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
    endfunction

    function automatic void grant(output logic g0, output logic g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset_n && en) begin
            if (v0 && v1) begin
                g0 = (m_pri == 1'b0);
                g1 = (m_pri == 1'b1);
            end else begin
                g0 = v0;
                g1 = v1;
            end
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_pri = 1'b0;
        m_s1  = '0;
        m_s2  = '0;
    endtask

    task automatic check_cycle();
        logic         g0;
        logic         g1;
        logic         e0;
        logic         e1;
        logic         eb;
        logic [W-1:0] er;
        op_t          keep[$];
        if (!reset_n) model_reset();
        grant(g0, g1);
        for (int d = 0; d < 2; d++) begin
            e0 = 1'b0;
            e1 = 1'b0;
            er = '0;
            eb = g0 | g1;
            foreach (q[i]) begin
                if (q[i].dut == d && q[i].due == cyc) begin
                    e0 = ~q[i].port;
                    e1 = q[i].port;
                    er = q[i].prod;
                end
                if (q[i].dut == d && q[i].due > cyc) eb = 1'b1;
            end
            chk("ready0", d, {31'd0, rdy0[d]}, {31'd0, g0});
            chk("ready1", d, {31'd0, rdy1[d]}, {31'd0, g1});
            chk("rsp0_valid", d, {31'd0, rv0[d]}, {31'd0, e0});
            chk("rsp1_valid", d, {31'd0, rv1[d]}, {31'd0, e1});
            chk("rsp0_result", d, rr0[d], e0 ? er : '0);
            chk("rsp1_result", d, rr1[d], e1 ? er : '0);
            chk("busy", d, {31'd0, bsy[d]}, {31'd0, eb});
            chk("mul_src1", d, ms1[d], m_s1);
            chk("mul_src2", d, ms2[d], m_s2);
        end
        foreach (q[i]) if (q[i].due > cyc) keep.push_back(q[i]);
        q = keep;
    endtask

    task automatic model_update();
        logic g0;
        logic g1;
        op_t  op;
        grant(g0, g1);
        if (!reset_n) begin
            model_reset();
        end else if (g0 | g1) begin
            op.port = g1;
            op.prod = g1 ? a1 * b1 : a0 * b0;
            op.due  = cyc + 2;
            op.dut  = 0;
            q.push_back(op);
            op.due  = cyc + 4;
            op.dut  = 1;
            q.push_back(op);
            m_pri = ~g1;
            m_s1  = g1 ? a1 : a0;
            m_s2  = g1 ? b1 : b0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic p0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic p1, input logic [W-1:0] x1, input logic [W-1:0] y1);
        v0 = p0; a0 = x0; b0 = y0;
        v1 = p1; a1 = x1; b1 = y1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) tick();
        reset_n = 1'b1;
    endtask

    // Checks the table's own expected product in the cycle instance d should respond.
    task automatic tab_cycle(input int d, input int i);
        @(negedge clk);
        check_cycle();
        chk("tab_valid", d, {31'd0, tab[i].port ? rv1[d] : rv0[d]}, 32'd1);
        chk("tab_result", d, tab[i].port ? rr1[d] : rr0[d], tab[i].prod);
        chk("tab_other", d, {31'd0, tab[i].port ? rv0[d] : rv1[d]}, 32'd0);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        en      = 1'b1;
        model_reset();
        tab[0] = '{1'b0, 32'd7, 32'd6, 32'd42};
        tab[1] = '{1'b0, 32'd3, 32'd5, 32'd15};
        tab[2] = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        tab[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tab[4] = '{1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF};
        tab[5] = '{1'b1, 32'h8000_0000, 32'd2, 32'h0000_0000};
        tab[6] = '{1'b0, 32'h1234_5678, 32'd16, 32'h2345_6780};

        do_reset(3);
        tick();

        // Single ops from the table; source changes after acceptance must not matter.
        for (int i = 0; i < 7; i++) begin
            drive(~tab[i].port, tab[i].a, tab[i].b, tab[i].port, tab[i].a, tab[i].b);
            tick();
            drive(1'b0, 32'hDEAD_BEEF, 32'h1, 1'b0, 32'hDEAD_BEEF, 32'h1);
            tick();
            tab_cycle(0, i);
            tick();
            tab_cycle(1, i);
        end

        // Continuous contention from reset: grants alternate starting at port 0.
        do_reset(2);
        drive(1'b1, 32'd3, 32'd5, 1'b1, 32'h0001_0000, 32'h0001_0000);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_cycle();
            chk("alternate", 0, {31'd0, rdy0[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk);
            model_update();
            #1;
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) tick();

        // en drops while port 1 waits; port 1 wins once en returns.
        do_reset(2);
        drive(1'b1, 32'd9, 32'd9, 1'b0, '0, '0);
        tick();
        en = 1'b0;
        drive(1'b1, 32'd4, 32'd4, 1'b1, 32'd2, 32'd2);
        for (int k = 0; k < 5; k++) tick();
        en = 1'b1;
        @(negedge clk);
        check_cycle();
        chk("en_return_p1", 0, {31'd0, rdy1[0]}, 32'd1);
        chk("en_return_p0", 0, {31'd0, rdy0[0]}, 32'd0);
        @(posedge clk);
        model_update();
        #1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) tick();

        // Reset right after an acceptance: the op never responds; port 0 first after release.
        drive(1'b1, 32'd11, 32'd13, 1'b0, '0, '0);
        tick();
        reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        check_cycle();
        chk("reset_busy", 0, {31'd0, bsy[0]}, 32'd0);
        @(posedge clk);
        model_update();
        #1;
        tick();
        reset_n = 1'b1;
        drive(1'b1, 32'd1, 32'd2, 1'b1, 32'd3, 32'd4);
        @(negedge clk);
        check_cycle();
        chk("post_reset_p0", 0, {31'd0, rdy0[0]}, 32'd1);
        chk("post_reset_l3", 1, {31'd0, rdy0[1]}, 32'd1);
        @(posedge clk);
        model_update();
        #1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 6; k++) tick();

        // Random traffic with occasional en drops and resets.
        for (int k = 0; k < 3000; k++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            en      = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom, $urandom);
            tick();
        end
        reset_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int k = 0; k < 6; k++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
